// File: rtl/task2_pkg.sv
// Shared definitions for the task2 4-input function cell: the default
// truth table and the lookup index type.
package task2_pkg;

  // y = (a & b) | (~c & d), bit i = value for index {a,b,c,d} == i
  localparam logic [15:0] TASK2_DEFAULT_TT = 16'hF222;

  typedef logic [3:0] lut4_idx_t;

endpackage

// File: rtl/task2_lut4_comb.sv
// Pure combinational 16:1 table lookup; the table is a parameter so the
// same cell implements any 4-input Boolean function.
module lut4_comb
  import task2_pkg::*;
#(
  parameter logic [15:0] TRUTH_TABLE = TASK2_DEFAULT_TT
) (
  input  lut4_idx_t idx,
  output logic      f
);

  assign f = TRUTH_TABLE[idx];

endmodule

// File: rtl/task2.sv
// 4-input Boolean function with a registered output: y follows
// TRUTH_TABLE[{a,b,c,d}] one clock later, async-reset to RESET_VALUE.
module task2
  import task2_pkg::*;
#(
  parameter logic [15:0] TRUTH_TABLE = TASK2_DEFAULT_TT,
  parameter logic        RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic y
);

  lut4_idx_t idx;
  logic      f;

  assign idx = {a, b, c, d};

  lut4_comb #(
    .TRUTH_TABLE(TRUTH_TABLE)
  ) u_lut (
    .idx(idx),
    .f  (f)
  );

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples values from before the edge, independent of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y <= RESET_VALUE;
    end else begin
      y <= f;
    end
  end

endmodule

// File: tb/tb_task2.sv
// Self-checking bench for task2: default table and an XOR-parity override,
// both compared against Boolean/arithmetic reference models.
module tb_task2;

  logic clk;
  logic rst_n;
  logic a, b, c, d;
  logic y_def;
  logic y_par;

  int checks = 0;
  int errors = 0;

  // Expected outputs, maintained by the reference model
  logic exp_def;
  logic exp_par;

  task2 u_dut_def (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .c    (c),
    .d    (d),
    .y    (y_def)
  );

  task2 #(
    .TRUTH_TABLE(16'h6996),
    .RESET_VALUE(1'b0)
  ) u_dut_par (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .c    (c),
    .d    (d),
    .y    (y_par)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference functions written from the Boolean description
  function automatic logic ref_def(input logic [3:0] v);
    return (v[3] & v[2]) | (~v[1] & v[0]);
  endfunction

  function automatic logic ref_par(input logic [3:0] v);
    return logic'($countones(v) % 2);
  endfunction

  task automatic drive(input logic [3:0] v);
    {a, b, c, d} = v;
  endtask

  // Drive at the falling edge, let one rising edge capture, check #1 later
  task automatic step(input logic [3:0] v, input string tag);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    if (rst_n) begin
      exp_def = ref_def(v);
      exp_par = ref_par(v);
    end
    check({tag, "_def"}, y_def, exp_def);
    check({tag, "_par"}, y_par, exp_par);
  endtask

  initial begin
    logic [3:0] prev;
    rst_n = 1'b0;
    drive(4'b1111);
    exp_def = 1'b0;
    exp_par = 1'b0;

    // Reset held with all-ones inputs: y stays low across edges
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_hold_def", y_def, 1'b0);
      check("rst_hold_par", y_par, 1'b0);
    end

    // Release away from an edge, then capture 1111 (default f = 1)
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1111, "pre_async");

    // Async assert mid-cycle: y must drop before the next edge
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_def", y_def, 1'b0);
    check("async_rst_par", y_par, 1'b0);
    exp_def = 1'b0;
    exp_par = 1'b0;

    // Release with 1101: first full edge gives default 1, parity 1
    @(negedge clk);
    drive(4'b1101);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release_def", y_def, 1'b1);
    check("release_par", y_par, 1'b1);

    // Exhaustive sweep of both tables
    for (int i = 0; i < 16; i++) begin
      step(4'(i), $sformatf("sweep%0d", i));
    end

    // Latency/hold: mid-cycle input change does not reach y until an edge
    step(4'b0000, "hold_base");
    #1;
    drive(4'b1100);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_mid_def", y_def, 1'b0);
    end
    @(posedge clk);
    #1;
    check("hold_edge_def", y_def, 1'b1);
    check("hold_edge_par", y_par, 1'b0);

    // Back-to-back alternation, one-cycle lag
    for (int i = 0; i < 8; i++) begin
      step((i % 2 == 0) ? 4'b0001 : 4'b0010, "toggle");
    end

    // Randomised traffic with occasional mid-cycle reset pulses
    prev = 4'b0000;
    for (int i = 0; i < 300; i++) begin
      prev = 4'($urandom_range(0, 15));
      step(prev, "rand");
      if ($urandom_range(0, 15) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        exp_def = 1'b0;
        exp_par = 1'b0;
        check("rand_rst_def", y_def, exp_def);
        check("rand_rst_par", y_par, exp_par);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/task2.md
Name: task2

Overview:
- Four-input, single-output Boolean function block with a registered output.
- Evaluates a fixed 16-entry truth table indexed by {a,b,c,d} and presents the result on y one clock later.
- Used as a leaf glue-logic cell. The function is parameterised so the same block can be reused for other 4-input functions.

Parameters:
- TRUTH_TABLE, 16'hF222, bit i is the value of y for input index i = {a,b,c,d} (a = MSB, d = LSB). The default implements y = (a & b) | (~c & d).
- RESET_VALUE, 1'b0, value loaded into y while reset is asserted.

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- a  input  1  function input, index bit 3 (MSB)
- b  input  1  function input, index bit 2
- c  input  1  function input, index bit 1
- d  input  1  function input, index bit 0 (LSB)
- y  output  1  registered function result

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Index formation: idx[3:0] = {a,b,c,d}; f = TRUTH_TABLE[idx]. This is purely combinational, with no other logic on the path.
- Register: on each rising clk edge with rst_n = 1, y <= f.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on y after edge N, and y holds that value until edge N+1.
- Reset asserted (rst_n = 0):
  - y is forced to RESET_VALUE immediately, independent of clk.
  - y stays there for as long as rst_n is low.
- Reset release: on the first rising edge with rst_n = 1, y takes the function of the inputs sampled at that edge.
  - rst_n deasserting coincident with a clock edge may or may not capture on that edge. Synchronising the release is the system's responsibility.
- Reset mid-operation: any pending result is discarded. No other state exists.
- Inputs are treated as synchronous to clk, and no synchroniser is included. X/Z on any input may propagate X to y; no masking is applied.
- Input changes between edges have no effect on y. No glitches appear on y.
- There is no handshake, no enable and no FSM. The block is always active.
- Default-function truth (idx: y):
  - 0: 0, 1: 1, 2: 0, 3: 0
  - 4: 0, 5: 1, 6: 0, 7: 0
  - 8: 0, 9: 1, 10: 0, 11: 0
  - 12: 1, 13: 1, 14: 1, 15: 1

Decomposition:
- Shared package: the default truth-table constant (TASK2_DEFAULT_TT = 16'hF222) and a 4-bit index typedef (lut4_idx_t).
- One sub-module is natural: lut4_comb, the pure combinational 16:1 table lookup. task2 wraps it with the reset-able output flop.
- No further hierarchy.

Test Plan:
- Reset: hold rst_n = 0 with inputs = 4'b1111 for 3 cycles -> y = 0 throughout. Assert rst_n low asynchronously between edges while y = 1 -> y drops to 0 before the next edge.
- Exhaustive sweep, default table: after reset, apply {a,b,c,d} = 0..15, one value per cycle. One cycle later y must be 0,1,0,0,0,1,0,0,0,1,0,0,1,1,1,1.
- Latency/hold: change inputs from 4'b0000 to 4'b1100 mid-cycle -> y remains 0 until the next rising edge, then becomes 1. No change occurs between edges.
- Back-to-back toggling: alternate 4'b0001 / 4'b0010 every cycle -> y alternates 1/0, each value lagging its input by exactly one cycle.
- Parameter override: instantiate with TRUTH_TABLE = 16'h6996 (XOR parity) and sweep 0..15 -> y = odd parity of idx, e.g. idx 7 -> 1, idx 15 -> 0.
- Reset release: deassert rst_n with inputs = 4'b1101 -> y = 1 after the first full rising edge following release.
